// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the E stage; long ops run a fixed latency under busy.
// Optional MADD/MADDU accumulate support is enabled by defining MD_MADD_EN.
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int unsigned MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7
  } op_e;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] pend_q, pend_d;
  logic               wr_q, wr_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dz_q, dz_d;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               sign_div, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   mag_a, mag_b, divisor, q_mag, r_mag, quot, rem;

  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Signed divide via magnitudes; MIN/-1 falls out naturally as quotient MIN, remainder 0.
  assign sign_div = (op == OP_DIV);
  assign a_neg    = sign_div & a[WIDTH-1];
  assign b_neg    = sign_div & b[WIDTH-1];
  assign b_zero   = (b == '0);
  assign mag_a    = a_neg ? -a : a;
  assign mag_b    = b_neg ? -b : b;
  assign divisor  = b_zero ? WIDTH'(1) : mag_b;
  assign q_mag    = mag_a / divisor;
  assign r_mag    = mag_a % divisor;
  assign quot     = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem      = a_neg ? -r_mag : r_mag;

`ifdef MD_MADD_EN
  logic [2*WIDTH-1:0] acc_s, acc_u;
  assign acc_s = {hi_q, lo_q} + prod_s;
  assign acc_u = {hi_q, lo_q} + prod_u;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    wr_d    = wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              pend_d  = (op == OP_MULT) ? prod_s : prod_u;
              wr_d    = 1'b1;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              pend_d  = {rem, quot};
              wr_d    = ~b_zero;
              dz_d    = dz_q | b_zero;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = S_RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
`ifdef MD_MADD_EN
            OP_MADD, OP_MADDU: begin
              pend_d  = (op == OP_MADD) ? acc_s : acc_u;
              wr_d    = 1'b1;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = S_RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          wr_d    = 1'b0;
          if (wr_q) begin
            hi_d = pend_q[2*WIDTH-1:WIDTH];
            lo_d = pend_q[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      wr_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: a reference model queues expected HI/LO/dz with due cycles,
// a negedge monitor compares every cycle. Define MD_MADD_EN identically for bench and design.
module tb_md_unit;
  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    op = '0;
  logic [W-1:0]  a = '0, b = '0;
  logic          busy, dz;
  logic [W-1:0]  hi, lo;

  md_unit #(.WIDTH(W), .MULT_CYCLES(ML), .DIV_CYCLES(DL)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo), .dz(dz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_dz = 1'b0;
  logic [31:0] vis_hi = '0, vis_lo = '0;
  logic        vis_dz = 1'b0;
  int          busy_end = 0;
  int          n_chk = 0, n_pass = 0;
  bit          done = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    if (!done) begin
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        exp_t e;
        e = sbq.pop_front();
        vis_hi = e.hi;
        vis_lo = e.lo;
        vis_dz = e.dz;
      end
      check("busy", 64'(busy), 64'(cyc < busy_end));
      check("hilo", {hi, lo}, {vis_hi, vis_lo});
      check("dz", 64'(dz), 64'(vis_dz));
    end
  end

  // Reference model: results from plain arithmetic on the operands.
  task automatic issue(logic [3:0] o, logic [31:0] x, logic [31:0] y, bit wait_done = 1'b1);
    int k, lat, dsx, dsy;
    longint sx, sy;
    longint unsigned ux, uy, p;
    logic [31:0] nhi, nlo;
    bit accepted, dzset;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = cyc;
    lat = 0; dzset = 1'b0; accepted = 1'b0;
    nhi = m_hi; nlo = m_lo;
    if (k > busy_end) begin
      sx = $signed(x); sy = $signed(y);
      ux = x; uy = y;
      case (o)
        4'd0: begin p = sx * sy; {nhi, nlo} = p; lat = ML; accepted = 1'b1; end
        4'd1: begin p = ux * uy; {nhi, nlo} = p; lat = ML; accepted = 1'b1; end
        4'd2: begin
          lat = DL; accepted = 1'b1;
          if (y == 0) dzset = 1'b1;
          else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin nlo = x; nhi = 0; end
          else begin dsx = x; dsy = y; nlo = dsx / dsy; nhi = dsx % dsy; end
        end
        4'd3: begin
          lat = DL; accepted = 1'b1;
          if (y == 0) dzset = 1'b1;
          else begin nlo = x / y; nhi = x % y; end
        end
        4'd4: begin nhi = x; accepted = 1'b1; end
        4'd5: begin nlo = x; accepted = 1'b1; end
`ifdef MD_MADD_EN
        4'd6: begin p = {m_hi, m_lo} + longint'(sx * sy); {nhi, nlo} = p; lat = ML; accepted = 1'b1; end
        4'd7: begin p = {m_hi, m_lo} + ux * uy; {nhi, nlo} = p; lat = ML; accepted = 1'b1; end
`endif
        default: ;
      endcase
    end
    if (accepted) begin
      if (dzset) begin
        m_dz = 1'b1;
        sbq.push_back('{k, m_hi, m_lo, 1'b1});
      end
      sbq.push_back('{k + lat, nhi, nlo, m_dz});
      if (lat > 0) busy_end = k + lat;
      m_hi = nhi;
      m_lo = nlo;
      if (wait_done && lat > 0) repeat (lat) @(negedge clk);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;

    issue(4'd0, 32'hFFFF_FFFE, 32'd3);
    settle();
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFFA);
    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    settle();
    check("multu_hilo", {hi, lo}, 64'h0000_0002_FFFF_FFFA);

    issue(4'd4, 32'h0000_ABCD, 32'd0);
    settle();
    check("mthi_hi", 64'(hi), 64'h0000_ABCD);
    check("mthi_busy", 64'(busy), 64'h0);

    issue(4'd2, 32'hFFFF_FFF9, 32'd2);
    settle();
    check("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    settle();
    check("div_min_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

    issue(4'd4, 32'h11, 32'd0);
    issue(4'd5, 32'h22, 32'd0);
    issue(4'd3, 32'd5, 32'd0);
    settle();
    check("divz_hilo", {hi, lo}, 64'h0000_0011_0000_0022);
    check("divz_dz", 64'(dz), 64'h1);

    issue(4'd2, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    issue(4'd0, 32'd3, 32'd4, 1'b0);
    repeat (DL) @(negedge clk);
    settle();
    check("div_ignore_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

    issue(4'd4, 32'h0, 32'd0);
    issue(4'd5, 32'hFFFF_FFFF, 32'd0);
    issue(4'd7, 32'd1, 32'd1);
    settle();
`ifdef MD_MADD_EN
    check("maddu_hilo", {hi, lo}, 64'h0000_0001_0000_0000);
`else
    check("maddu_off_hilo", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
    check("maddu_off_busy", 64'(busy), 64'h0);
`endif

    // Reset arrives while a divide has 4 cycles left.
    issue(4'd2, 32'd1000, 32'd3, 1'b0);
    repeat (6) @(posedge clk);
    #2;
    reset = 1'b0;
    sbq.delete();
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    vis_hi = '0; vis_lo = '0; vis_dz = 1'b0;
    busy_end = 0;
    #1;
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_hilo", {hi, lo}, 64'h0);
    @(negedge clk);
    #2 reset = 1'b1;
    issue(4'd5, 32'd1, 32'd0);
    settle();
    check("rst_mtlo", 64'(lo), 64'h1);

    for (int i = 0; i < 80; i++) begin
      logic [3:0] o;
      if ($urandom_range(0, 3) == 0) o = 4'($urandom_range(8, 15));
      else o = 4'($urandom_range(0, 7));
      issue(o, rnd_operand(), rnd_operand(), $urandom_range(0, 3) != 0);
    end

    repeat (DL + 2) @(negedge clk);
    #1;
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
